coprocessor_control_unit: RTL

Host-facing sequencer that drives the matrix ALU. Accepts 32-bit instructions over a valid/ready handshake, loads operand elements into internal A/B/scalar registers, issues an ALU opcode and waits for the ALU's `done`, then captures the result matrix and overflow flag for element-wise readback. Sits between the host bus bridge and the ALU.

---
 rtl/coprocessor_pkg.sv | 65 ++++++
 rtl/matrix_bank.sv | 63 ++++++
 rtl/coprocessor_control_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/coprocessor_pkg.sv
// Shared definitions for the coprocessor control unit: instruction field
// layout, command and ALU opcode codes, target selects and FSM states.
package coprocessor_pkg;

  localparam int unsigned ELEM_W_DEF  = 8;
  localparam int unsigned N_ELEM_DEF  = 25;
  localparam int unsigned TIMEOUT_DEF = 16;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned TGT_W   = 2;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DATA_W  = 8;

  // Bit positions of the instruction fields (target and alu_op overlap)
  localparam int unsigned CMD_LSB  = 0;
  localparam int unsigned TGT_LSB  = 4;
  localparam int unsigned OP_LSB   = 4;
  localparam int unsigned IDX_LSB  = 7;
  localparam int unsigned DATA_LSB = 12;
  localparam int unsigned FIELD_W  = DATA_LSB + DATA_W;

  localparam logic [CMD_W-1:0] CMD_NOP   = 4'h0;
  localparam logic [CMD_W-1:0] CMD_LOAD  = 4'h1;
  localparam logic [CMD_W-1:0] CMD_READ  = 4'h2;
  localparam logic [CMD_W-1:0] CMD_EXEC  = 4'h3;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 4'h4;

  localparam logic [OP_W-1:0] OP_NONE      = 3'b000;
  localparam logic [OP_W-1:0] OP_SUM       = 3'b001;
  localparam logic [OP_W-1:0] OP_DIFF      = 3'b010;
  localparam logic [OP_W-1:0] OP_MUL       = 3'b011;
  localparam logic [OP_W-1:0] OP_SCALE     = 3'b100;
  localparam logic [OP_W-1:0] OP_TRANSPOSE = 3'b101;
  localparam logic [OP_W-1:0] OP_TRACE     = 3'b110;
  localparam logic [OP_W-1:0] OP_DET       = 3'b111;

  typedef enum logic [TGT_W-1:0] {
    TGT_A    = 2'b00,
    TGT_B    = 2'b01,
    TGT_F    = 2'b10,
    TGT_RSVD = 2'b11
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  // Decoded view of instr[19:0]; target is op[1:0]
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  index;
    logic [OP_W-1:0]   op;
    logic [CMD_W-1:0]  cmd;
  } instr_fields_t;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                        input int unsigned     n);
    return 32'(idx) < n;
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// Operand storage for the ALU: matrices A and B plus scalar f.
// Ports: clk/rst, single element write port (we, target, index, data),
// synchronous clear, flat outputs a_flat/b_flat (element i at [W*i +: W]) and f.
module matrix_bank
  import coprocessor_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned N_ELEM = N_ELEM_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     clear,
  input  target_e                  target,
  input  logic [IDX_W-1:0]         index,
  input  logic [ELEM_W-1:0]        data,
  output logic [N_ELEM*ELEM_W-1:0] a_flat,
  output logic [N_ELEM*ELEM_W-1:0] b_flat,
  output logic [ELEM_W-1:0]        f
);

  localparam int unsigned FLAT_W = N_ELEM * ELEM_W;

  logic [FLAT_W-1:0] a_q, a_d;
  logic [FLAT_W-1:0] b_q, b_d;
  logic [ELEM_W-1:0] f_q, f_d;

  // Next-state: clear wins over write; caller guarantees index is in range
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    f_d = f_q;
    if (clear) begin
      a_d = '0;
      b_d = '0;
      f_d = '0;
    end else if (we) begin
      case (target)
        TGT_A:   a_d[32'(index)*ELEM_W +: ELEM_W] = data;
        TGT_B:   b_d[32'(index)*ELEM_W +: ELEM_W] = data;
        TGT_F:   f_d = data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      f_q <= f_d;
    end
  end

  assign a_flat = a_q;
  assign b_flat = b_q;
  assign f      = f_q;

endmodule

// File: rtl/coprocessor_control_unit.sv
// Host-facing sequencer for the matrix ALU. Accepts instructions over a
// valid/ready handshake, loads operands, runs ALU operations with a timeout
// and captures the result matrix for element-wise readback.
// Ports: clk/rst; host side instr/instr_valid/instr_ready, result_data/
// result_valid, op_done, busy, ovf, err; ALU side A_flat/B_flat/f/opcode
// out, C_flat/overflow_flag/done in.
module coprocessor_control_unit
  import coprocessor_pkg::*;
#(
  parameter int unsigned ELEM_W  = ELEM_W_DEF,
  parameter int unsigned N_ELEM  = N_ELEM_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_W-1:0]       instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic [ELEM_W-1:0]        result_data,
  output logic                     result_valid,
  output logic                     op_done,
  output logic                     busy,
  output logic                     ovf,
  output logic                     err,
  output logic [N_ELEM*ELEM_W-1:0] A_flat,
  output logic [N_ELEM*ELEM_W-1:0] B_flat,
  output logic [ELEM_W-1:0]        f,
  output logic [OP_W-1:0]          opcode,
  input  logic [N_ELEM*ELEM_W-1:0] C_flat,
  input  logic                     overflow_flag,
  input  logic                     done
);

  localparam int unsigned FLAT_W = N_ELEM * ELEM_W;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic               ready_q;
  logic               busy_q;
  logic [OP_W-1:0]    opcode_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [FLAT_W-1:0]  c_q;
  logic [ELEM_W-1:0]  result_data_q;
  logic               result_valid_q;
  logic               op_done_q;
  logic               ovf_q;
  logic               err_q;

  instr_fields_t      fld;
  target_e            tgt;
  logic               unused_instr_bits;
  logic               accept;
  logic               idx_ok;
  logic               load_ok;
  logic               bank_we;
  logic               bank_clear;
  logic [IDX_W-1:0]   rd_idx;

  // Instruction decode
  assign fld               = instr_fields_t'(instr[FIELD_W-1:0]);
  assign unused_instr_bits = ^instr[INSTR_W-1:FIELD_W];
  assign tgt               = target_e'(fld.op[TGT_W-1:0]);
  assign accept            = instr_valid && ready_q;
  assign idx_ok            = idx_in_range(fld.index, N_ELEM);
  // The scalar target ignores index, so only A/B loads need the range check
  assign load_ok           = (tgt == TGT_F) || (((tgt == TGT_A) || (tgt == TGT_B)) && idx_ok);
  assign bank_we           = accept && (fld.cmd == CMD_LOAD) && load_ok;
  assign bank_clear        = accept && (fld.cmd == CMD_CLEAR);
  // Clamp keeps the C read select in range; the out-of-range value is discarded
  assign rd_idx            = idx_ok ? fld.index : '0;

  matrix_bank #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (bank_we),
    .clear  (bank_clear),
    .target (tgt),
    .index  (fld.index),
    .data   (ELEM_W'(fld.data)),
    .a_flat (A_flat),
    .b_flat (B_flat),
    .f      (f)
  );

  // Sequencer FSM with registered host and ALU outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      opcode_q       <= OP_NONE;
      wait_cnt_q     <= '0;
      c_q            <= '0;
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
      op_done_q      <= 1'b0;
      ovf_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      op_done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (fld.cmd)
              CMD_NOP: ;
              CMD_LOAD: begin
                if (!load_ok) err_q <= 1'b1;
              end
              CMD_READ: begin
                result_valid_q <= 1'b1;
                result_data_q  <= idx_ok ? c_q[32'(rd_idx)*ELEM_W +: ELEM_W] : '0;
                if (!idx_ok) err_q <= 1'b1;
              end
              CMD_EXEC: begin
                if (fld.op == OP_NONE) begin
                  err_q     <= 1'b1;
                  op_done_q <= 1'b1;
                end else begin
                  state_q  <= ST_ISSUE;
                  opcode_q <= fld.op;
                  busy_q   <= 1'b1;
                  ready_q  <= 1'b0;
                end
              end
              CMD_CLEAR: begin
                c_q   <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ST_ISSUE: begin
          state_q    <= ST_WAIT;
          wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (done || (wait_cnt_q == CNT_W'(TIMEOUT - 1))) begin
            if (done) begin
              c_q   <= C_flat;
              ovf_q <= overflow_flag;
            end else begin
              err_q <= 1'b1;
            end
            state_q   <= ST_IDLE;
            opcode_q  <= OP_NONE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            op_done_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          opcode_q <= OP_NONE;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready  = ready_q;
  assign busy         = busy_q;
  assign opcode       = opcode_q;
  assign result_data  = result_data_q;
  assign result_valid = result_valid_q;
  assign op_done      = op_done_q;
  assign ovf          = ovf_q;
  assign err          = err_q;

endmodule
